// File: rtl/elevator_request_scheduler.sv
// Latches hall/cab calls into a pending vector and picks the next target floor with a
// SCAN sweep, clearing calls once the car has sat idle at a floor for SETTLE_CYCLES.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS    = 3,
    parameter int FLOOR_W       = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic [1:0]            elevator_status,
    output logic [FLOOR_W-1:0]    request_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [1:0]            sweep_dir,
    output logic                  busy
);

    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  SETTLE_L = CNT_W'(SETTLE_CYCLES);
    localparam logic [FLOOR_W:0]  NF_L     = (FLOOR_W+1)'(NUM_FLOORS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_t;

    state_t                r_state, w_state_next;
    logic [NUM_FLOORS-1:0] r_btn_q, r_pending;
    logic [NUM_FLOORS-1:0] w_rise, w_serve_mask, w_pend_next;
    logic                  r_armed, r_busy;
    logic [FLOOR_W-1:0]    r_floor_q, r_req, w_req_next;
    logic [FLOOR_W-1:0]    w_lowest_above, w_highest_below;
    logic [1:0]            r_status_q;
    logic [CNT_W-1:0]      r_settle_cnt, w_settle_next;
    logic                  w_floor_ok, w_changed, w_settled, w_above, w_below;

    // r_armed masks the first cycle after reset so a button still held at release
    // only seeds r_btn_q instead of registering a call.
    always_comb begin
        w_rise     = call_btn & ~r_btn_q & {NUM_FLOORS{r_armed}};
        w_floor_ok = (elevator_status == 2'b00) && ({1'b0, current_floor} < NF_L);
        w_changed  = (current_floor != r_floor_q) || (elevator_status != r_status_q);
        w_settled  = w_floor_ok && !w_changed && (r_settle_cnt == SETTLE_L);
    end

    always_comb begin
        w_settle_next = r_settle_cnt;
        if (!w_floor_ok || w_changed) begin
            w_settle_next = '0;
        end else if (r_settle_cnt != SETTLE_L) begin
            w_settle_next = r_settle_cnt + 1'b1;
        end
    end

    // Serve is applied after the set, so a press at the settled floor is absorbed.
    always_comb begin
        w_serve_mask = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_serve_mask[f] = w_settled && (current_floor == FLOOR_W'(f));
        end
        w_pend_next = (r_pending | w_rise) & ~w_serve_mask;
    end

    always_comb begin
        w_above         = 1'b0;
        w_below         = 1'b0;
        w_lowest_above  = current_floor;
        w_highest_below = current_floor;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (w_pend_next[f] && (FLOOR_W'(f) > current_floor)) begin
                w_above        = 1'b1;
                w_lowest_above = FLOOR_W'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (w_pend_next[f] && (FLOOR_W'(f) < current_floor)) begin
                w_below         = 1'b1;
                w_highest_below = FLOOR_W'(f);
            end
        end
    end

    // Direction and target only move once the car is settled, so a moving car
    // never sees its target change underneath it.
    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        if (w_settled) begin
            case (r_state)
                S_DOWN: begin
                    if (w_below)      w_state_next = S_DOWN;
                    else if (w_above) w_state_next = S_UP;
                    else              w_state_next = S_IDLE;
                end
                default: begin
                    if (w_above)      w_state_next = S_UP;
                    else if (w_below) w_state_next = S_DOWN;
                    else              w_state_next = S_IDLE;
                end
            endcase
            case (w_state_next)
                S_UP:    w_req_next = w_lowest_above;
                S_DOWN:  w_req_next = w_highest_below;
                default: w_req_next = current_floor;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_btn_q      <= '0;
            r_armed      <= 1'b0;
            r_pending    <= '0;
            r_busy       <= 1'b0;
            r_req        <= '0;
            r_floor_q    <= '0;
            r_status_q   <= 2'b00;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_btn_q      <= call_btn;
            r_armed      <= 1'b1;
            r_pending    <= w_pend_next;
            r_busy       <= |w_pend_next;
            r_req        <= w_req_next;
            r_floor_q    <= current_floor;
            r_status_q   <= elevator_status;
            r_settle_cnt <= w_settle_next;
        end
    end

    assign request_floor = r_req;
    assign pending       = r_pending;
    assign sweep_dir     = r_state;
    assign busy          = r_busy;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler: a behavioural model predicts every
// cycle's outputs, a monitor compares them, and directed scenarios add explicit checks.
module tb_elevator_request_scheduler;

    localparam int NF = 3;
    localparam int FW = 2;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] call_btn = '0;
    logic [FW-1:0] current_floor = '0;
    logic [1:0]    elevator_status = 2'b00;
    logic [FW-1:0] request_floor;
    logic [NF-1:0] pending;
    logic [1:0]    sweep_dir;
    logic          busy;

    elevator_request_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .call_btn       (call_btn),
        .current_floor  (current_floor),
        .elevator_status(elevator_status),
        .request_floor  (request_floor),
        .pending        (pending),
        .sweep_dir      (sweep_dir),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [NF-1:0] pend;
        logic [FW-1:0] req;
        logic [1:0]    dir;
        logic          bsy;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state: plain ints and bit arrays.
    bit m_pend[NF];
    bit m_prev_btn[NF];
    bit m_armed;
    int m_fprev, m_sprev, m_cnt, m_dir, m_req;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [NF-1:0] b, input int fl, input int st);
        exp_t e;
        bit   valid, changed, settled, any;
        int   lo, hi;
        if (r) begin
            for (int f = 0; f < NF; f++) begin
                m_pend[f]     = 0;
                m_prev_btn[f] = 0;
            end
            m_armed = 0;
            m_fprev = 0;
            m_sprev = 0;
            m_cnt   = 0;
            m_dir   = 0;
            m_req   = 0;
        end else begin
            valid   = (st == 0) && (fl < NF);
            changed = (fl != m_fprev) || (st != m_sprev);
            settled = valid && !changed && (m_cnt == SC);
            for (int f = 0; f < NF; f++)
                if (m_armed && b[f] && !m_prev_btn[f]) m_pend[f] = 1;
            if (settled) begin
                m_pend[fl] = 0;
                lo = NF;
                hi = -1;
                for (int f = 0; f < NF; f++) begin
                    if (m_pend[f] && f > fl && lo == NF) lo = f;
                    if (m_pend[f] && f < fl) hi = f;
                end
                if (m_dir == 2) m_dir = (hi >= 0) ? 2 : (lo < NF) ? 1 : 0;
                else            m_dir = (lo < NF) ? 1 : (hi >= 0) ? 2 : 0;
                m_req = (m_dir == 1) ? lo : (m_dir == 2) ? hi : fl;
            end
            if (!valid || changed) m_cnt = 0;
            else if (m_cnt < SC)   m_cnt = m_cnt + 1;
            m_fprev = fl;
            m_sprev = st;
            m_armed = 1;
            for (int f = 0; f < NF; f++) m_prev_btn[f] = b[f];
        end
        any = 0;
        for (int f = 0; f < NF; f++) begin
            e.pend[f] = m_pend[f];
            any       = any | m_pend[f];
        end
        e.req = FW'(m_req);
        e.dir = 2'(m_dir);
        e.bsy = any;
        sb_q.push_back(e);
    endtask

    // One clock cycle of stimulus; the model predicts the outputs after the next rising edge.
    task automatic step(input bit r, input logic [NF-1:0] b, input int fl, input int st);
        @(negedge clk);
        rst             = r;
        call_btn        = b;
        current_floor   = fl[FW-1:0];
        elevator_status = st[1:0];
        model_step(r, b, fl, st);
    endtask

    task automatic hold(input int n, input logic [NF-1:0] b, input int fl, input int st);
        for (int i = 0; i < n; i++) step(1'b0, b, fl, st);
    endtask

    task automatic do_reset();
        step(1'b1, '0, 0, 0);
        step(1'b1, '0, 0, 0);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_pending", int'(pending), int'(e.pend));
            check("sb_request_floor", int'(request_floor), int'(e.req));
            check("sb_sweep_dir", int'(sweep_dir), int'(e.dir));
            check("sb_busy", int'(busy), int'(e.bsy));
        end
    end

    initial begin
        int  sets;
        bit  prev1;
        int  len, fl, st, rr;
        logic [NF-1:0] b;

        // Scenario 1: call for floor 2 from idle at floor 0
        do_reset();
        check("reset_pending", int'(pending), 0);
        check("reset_request", int'(request_floor), 0);
        check("reset_dir", int'(sweep_dir), 0);
        check("reset_busy", int'(busy), 0);
        hold(4, '0, 0, 0);
        step(1'b0, 3'b100, 0, 0);
        sample();
        check("t1_pending", int'(pending), 4);
        hold(3, '0, 0, 0);
        sample();
        check("t1_dir", int'(sweep_dir), 1);
        check("t1_request", int'(request_floor), 2);
        check("t1_busy", int'(busy), 1);

        // Scenario 2: travel to floor 2 and settle there
        hold(2, '0, 0, 1);
        hold(2, '0, 1, 1);
        hold(1, '0, 2, 1);
        hold(SC + 2, '0, 2, 0);
        sample();
        check("t2_pending", int'(pending), 0);
        check("t2_dir", int'(sweep_dir), 0);
        check("t2_request", int'(request_floor), 2);
        check("t2_busy", int'(busy), 0);

        // Scenario 3: call below while moving up keeps the current target
        do_reset();
        hold(4, '0, 1, 0);
        step(1'b0, 3'b100, 1, 0);
        step(1'b0, 3'b000, 1, 1);
        step(1'b0, 3'b001, 1, 1);
        step(1'b0, 3'b000, 1, 1);
        sample();
        check("t3_request_midmove", int'(request_floor), 2);
        check("t3_pending_midmove", int'(pending), 5);
        hold(1, '0, 2, 1);
        hold(SC + 2, '0, 2, 0);
        sample();
        check("t3_dir", int'(sweep_dir), 2);
        check("t3_request", int'(request_floor), 0);
        check("t3_pending", int'(pending), 1);

        // Scenario 4: calls above and below in the same cycle prefer up
        do_reset();
        hold(4, '0, 1, 0);
        step(1'b0, 3'b101, 1, 0);
        step(1'b0, 3'b000, 1, 0);
        sample();
        check("t4_pending", int'(pending), 5);
        check("t4_dir", int'(sweep_dir), 1);
        check("t4_request", int'(request_floor), 2);

        // Scenario 5: held button registers once
        do_reset();
        step(1'b0, '0, 1, 0);
        sets  = 0;
        prev1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'b010, 1, 0);
            sample();
            if (pending[1] && !prev1) sets++;
            prev1 = pending[1];
        end
        check("t5_set_count", sets, 1);
        check("t5_pending_final", int'(pending), 0);

        // Scenario 6: reset mid-move, then recovery
        do_reset();
        hold(4, '0, 2, 0);
        step(1'b0, 3'b011, 2, 0);
        step(1'b0, 3'b000, 2, 2);
        step(1'b0, 3'b000, 1, 2);
        sample();
        check("t6_pending_before", int'(pending), 3);
        check("t6_request_before", int'(request_floor), 1);
        step(1'b1, 3'b010, 1, 2);
        #1;
        check("t6_rst_pending", int'(pending), 0);
        check("t6_rst_request", int'(request_floor), 0);
        check("t6_rst_dir", int'(sweep_dir), 0);
        check("t6_rst_busy", int'(busy), 0);
        step(1'b1, 3'b010, 1, 2);
        hold(4, 3'b010, 0, 0);
        sample();
        check("t6_held_not_captured", int'(pending), 0);
        hold(3, '0, 0, 0);
        step(1'b0, 3'b100, 0, 0);
        step(1'b0, 3'b000, 0, 0);
        sample();
        check("t6_recover_dir", int'(sweep_dir), 1);
        check("t6_recover_request", int'(request_floor), 2);

        // Randomised phases: floor/status held for a few cycles, random button levels
        do_reset();
        for (int p = 0; p < 120; p++) begin
            len = $urandom_range(1, 6);
            fl  = $urandom_range(0, 3);
            rr  = $urandom_range(0, 9);
            st  = (rr < 6) ? 0 : (rr < 8) ? 1 : (rr < 9) ? 2 : 3;
            for (int i = 0; i < len; i++) begin
                for (int f = 0; f < NF; f++) b[f] = ($urandom_range(0, 99) < 20);
                step(($urandom_range(0, 199) == 0), b, fl, st);
            end
        end
        step(1'b0, '0, 0, 0);
        sample();
        sample();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
